// File: rtl/aes_round_sequencer_pkg.sv
// Shared constants and phase encoding for the byte-serial AES-128 encryption datapath,
// its round sequencer and the key schedule.
package aes_round_sequencer_pkg;

  localparam int AES_NUM_ROUNDS  = 10;
  localparam int AES_STATE_BYTES = 16;
  localparam int AES_SB_LAT      = 1;
  localparam int AES_SR_LAT      = 13;
  localparam int AES_MC_LAT      = 4;

  localparam int CNT_W   = 6;
  localparam int ROUND_W = 4;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_LOAD       = 3'd1,
    PH_SUBBYTE    = 3'd2,
    PH_SHIFTROWS  = 3'd3,
    PH_MIXCOLUMNS = 3'd4,
    PH_XOR_RK     = 3'd5
  } phase_e;

endpackage

// File: rtl/aes_round_sequencer_phase_counter.sv
// Per-phase byte counter: clears on phase change, holds while stalled or idle,
// and flags the final cycle of the current phase.
module phase_counter
  import aes_round_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == len - 1'b1);

endmodule

// File: rtl/aes_round_sequencer.sv
// Round/phase sequencer for the byte-serial AES-128 encryptor: walks LOAD and ten rounds of
// SUBBYTE/SHIFTROWS/MIXCOLUMNS/XOR_RK, stalling on the key schedule at the start of each key add.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES_NUM_ROUNDS,
  parameter int STATE_BYTES = AES_STATE_BYTES,
  parameter int SB_LAT      = AES_SB_LAT,
  parameter int SR_LAT      = AES_SR_LAT,
  parameter int MC_LAT      = AES_MC_LAT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               key_ready,
  output logic               busy,
  output logic               done,
  output logic [2:0]         phase,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic               out_valid,
  output logic               sr_en,
  output logic               mc_en,
  output logic [ROUND_W-1:0] round,
  output logic               rk_req
);

  localparam logic [CNT_W-1:0]   LEN_BYTES  = CNT_W'(STATE_BYTES);
  localparam logic [CNT_W-1:0]   LEN_SB     = CNT_W'(STATE_BYTES + SB_LAT);
  localparam logic [CNT_W-1:0]   LEN_SR     = CNT_W'(STATE_BYTES + SR_LAT);
  localparam logic [CNT_W-1:0]   LEN_MC     = CNT_W'(STATE_BYTES + MC_LAT);
  localparam logic [CNT_W-1:0]   LAT_SB     = CNT_W'(SB_LAT);
  localparam logic [CNT_W-1:0]   LAT_SR     = CNT_W'(SR_LAT);
  localparam logic [CNT_W-1:0]   LAT_MC     = CNT_W'(MC_LAT);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  function automatic logic [CNT_W-1:0] phase_len(input phase_e p);
    case (p)
      PH_SUBBYTE:    phase_len = LEN_SB;
      PH_SHIFTROWS:  phase_len = LEN_SR;
      PH_MIXCOLUMNS: phase_len = LEN_MC;
      default:       phase_len = LEN_BYTES;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_lat(input phase_e p);
    case (p)
      PH_SUBBYTE:    phase_lat = LAT_SB;
      PH_SHIFTROWS:  phase_lat = LAT_SR;
      PH_MIXCOLUMNS: phase_lat = LAT_MC;
      default:       phase_lat = '0;
    endcase
  endfunction

  phase_e             phase_q, phase_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rk_req_q, rk_req_d;
  logic               cnt_clr, cnt_hold, cnt_last, stall;
  logic [CNT_W-1:0]   cnt;

  phase_counter u_phase_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr),
    .hold  (cnt_hold),
    .len   (phase_len(phase_q)),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // The key schedule is consulted only on the first byte of a key add.
  assign stall = (phase_q == PH_XOR_RK) && (cnt == '0) && !key_ready;

  always_comb begin
    phase_d  = phase_q;
    round_d  = round_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rk_req_d = 1'b0;
    cnt_clr  = 1'b0;
    cnt_hold = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        cnt_hold = 1'b1;
        if (start) begin
          phase_d = PH_LOAD;
          busy_d  = 1'b1;
          round_d = '0;
          cnt_clr = 1'b1;
        end
      end
      PH_LOAD: begin
        if (cnt_last) begin
          phase_d  = PH_SUBBYTE;
          round_d  = 4'd1;
          rk_req_d = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      PH_SUBBYTE: begin
        if (cnt_last) begin
          phase_d = PH_SHIFTROWS;
          cnt_clr = 1'b1;
        end
      end
      PH_SHIFTROWS: begin
        if (cnt_last) begin
          phase_d = (round_q < LAST_ROUND) ? PH_MIXCOLUMNS : PH_XOR_RK;
          cnt_clr = 1'b1;
        end
      end
      PH_MIXCOLUMNS: begin
        if (cnt_last) begin
          phase_d = PH_XOR_RK;
          cnt_clr = 1'b1;
        end
      end
      PH_XOR_RK: begin
        if (stall) begin
          cnt_hold = 1'b1;
        end else if (cnt_last) begin
          cnt_clr = 1'b1;
          if (round_q < LAST_ROUND) begin
            phase_d  = PH_SUBBYTE;
            round_d  = round_q + 4'd1;
            rk_req_d = 1'b1;
          end else begin
            phase_d = PH_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        phase_d = PH_IDLE;
        busy_d  = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rk_req_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      round_q  <= round_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rk_req_q <= rk_req_d;
    end
  end

  assign phase     = phase_q;
  assign byte_cnt  = cnt;
  assign round     = round_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rk_req    = rk_req_q;
  assign out_valid = (phase_q != PH_IDLE) && (cnt >= phase_lat(phase_q)) && !stall;
  assign sr_en     = (phase_q == PH_SHIFTROWS);
  assign mc_en     = (phase_q == PH_MIXCOLUMNS) && (cnt[1:0] != 2'b00);

endmodule
